// File: rtl/vce_palette_engine.sv
`default_nettype none
// ============================================================================
// Module   : vce_palette_engine
// Purpose  : Video colour encoder. Holds a CPU-writable colour RAM, maps VDC
//            pixel indices to expanded RGB, and generates the pixel-clock
//            enable from a programmable divider.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module vce_palette_engine #(
    parameter int ENTRIES  = 512,
    parameter int CBITS    = 3,
    parameter int OUT_BITS = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       CS_n,
    input  logic                       WR_n,
    input  logic                       RD_n,
    input  logic [2:0]                 A,
    input  logic [7:0]                 D_in,
    output logic [7:0]                 D_out,
    output logic                       D_oe,
    input  logic [$clog2(ENTRIES)-1:0] VD,
    input  logic                       HSYN,
    input  logic                       VSYN,
    output logic [OUT_BITS-1:0]        VIDEO_R,
    output logic [OUT_BITS-1:0]        VIDEO_G,
    output logic [OUT_BITS-1:0]        VIDEO_B,
    output logic                       VIDEO_VALID,
    output logic                       CK,
    output logic [1:0]                 MODE
);

    localparam int AW = $clog2(ENTRIES);
    localparam int EW = 3 * CBITS;
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_cr;
    logic [AW-1:0]      r_addr;
    logic [7:0]         r_low_hold;
    logic [7:0]         r_dout;

    logic [EW-1:0]      r_cram [ENTRIES];
    logic [EW-1:0]      r_px_entry;
    logic               r_px_valid;
    logic               r_px_blank;

    logic [1:0]         r_div;
    logic [1:0]         w_div_last;
    logic [1:0]         w_div_next;
    logic               r_ck;

    logic [OUT_BITS-1:0] r_video_r;
    logic [OUT_BITS-1:0] r_video_g;
    logic [OUT_BITS-1:0] r_video_b;
    logic                r_video_valid;

    logic               w_wr_act;
    logic               w_rd_act;
    logic               w_commit;
    logic               w_cr_write;
    logic [15:0]        w_addr16;
    logic [15:0]        w_addr_cand;
    logic [AW-1:0]      w_addr_inc;
    logic [15:0]        w_rd16;
    logic [EW-1:0]      w_wdata;

    // Replicate the channel bits MSB-first until OUT_BITS are filled.
    function automatic logic [OUT_BITS-1:0] f_expand(input logic [CBITS-1:0] c);
        logic [OUT_BITS-1:0] v;
        v = '0;
        for (int j = 0; j < OUT_BITS; j++) begin
            v[OUT_BITS-1-j] = c[CBITS-1-(j % CBITS)];
        end
        return v;
    endfunction

    // A single action fires in ACCESS; a write wins over a simultaneous read.
    assign w_wr_act   = (r_state == ST_ACCESS) && !CS_n && !WR_n && !reset;
    assign w_rd_act   = (r_state == ST_ACCESS) && !CS_n && WR_n && !RD_n && !reset;
    assign w_commit   = w_wr_act && (A == 3'd5);
    assign w_cr_write = w_wr_act && (A == 3'd0);

    assign w_addr16   = 16'(r_addr);
    assign w_addr_inc = (r_addr == C_LAST_ADDR) ? '0 : r_addr + AW'(1);
    assign w_rd16     = 16'(r_cram[r_addr]);
    assign w_wdata    = EW'({D_in, r_low_hold});

    // Candidate address from a low- or high-byte write, before the modulo wrap.
    always_comb begin
        w_addr_cand = {w_addr16[15:8], D_in};
        if (A == 3'd3) begin
            w_addr_cand = {D_in, w_addr16[7:0]};
        end
    end

    // Access state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Access next-state: one action per strobe assertion, then wait for release.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (!CS_n && (!WR_n || !RD_n)) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_HOLD;
            ST_HOLD:   if (CS_n || (WR_n && RD_n)) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // CPU register file: control, address pointer, low holding byte, read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cr       <= 8'h00;
            r_addr     <= '0;
            r_low_hold <= 8'h00;
            r_dout     <= 8'h00;
        end else if (w_wr_act) begin
            case (A)
                3'd0: r_cr <= D_in;
                3'd2: r_addr <= AW'(w_addr_cand % 16'(ENTRIES));
                3'd3: if (AW > 8) r_addr <= AW'(w_addr_cand % 16'(ENTRIES));
                3'd4: r_low_hold <= D_in;
                3'd5: r_addr <= w_addr_inc;
                default: ;
            endcase
        end else if (w_rd_act) begin
            case (A)
                3'd0: r_dout <= r_cr;
                3'd4: r_dout <= w_rd16[7:0];
                3'd5: begin
                    r_dout <= w_rd16[15:8];
                    r_addr <= w_addr_inc;
                end
                default: r_dout <= 8'h00;
            endcase
        end
    end

    // Colour RAM: CPU commit port and read-first pixel lookup on CK.
    always_ff @(posedge clock) begin
        if (w_commit) begin
            r_cram[r_addr] <= w_wdata;
        end
        if (r_ck) begin
            r_px_entry <= r_cram[VD];
        end
    end

    // Divider terminal count selected by the mode bits.
    always_comb begin
        case (r_cr[1:0])
            2'd0:    w_div_last = 2'd3;
            2'd1:    w_div_last = 2'd2;
            default: w_div_last = 2'd1;
        endcase
        w_div_next = (r_div >= w_div_last) ? 2'd0 : r_div + 2'd1;
    end

    // Pixel divider; a CR write restarts the count.
    always_ff @(posedge clock) begin
        if (reset || w_cr_write) begin
            r_div <= 2'd0;
            r_ck  <= 1'b0;
        end else begin
            r_div <= w_div_next;
            r_ck  <= (w_div_next == w_div_last);
        end
    end

    // Pixel sample stage: capture sync state alongside the RAM lookup.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_px_valid <= 1'b0;
            r_px_blank <= 1'b0;
        end else begin
            r_px_valid <= r_ck;
            if (r_ck) begin
                r_px_blank <= !HSYN || !VSYN;
            end
        end
    end

    // Output stage: expand channels or blank, hold between updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_video_r     <= '0;
            r_video_g     <= '0;
            r_video_b     <= '0;
            r_video_valid <= 1'b0;
        end else begin
            r_video_valid <= r_px_valid;
            if (r_px_valid) begin
                if (r_px_blank) begin
                    r_video_r <= '0;
                    r_video_g <= '0;
                    r_video_b <= '0;
                end else begin
                    r_video_r <= f_expand(r_px_entry[2*CBITS-1:CBITS]);
                    r_video_g <= f_expand(r_px_entry[EW-1:2*CBITS]);
                    r_video_b <= f_expand(r_px_entry[CBITS-1:0]);
                end
            end
        end
    end

    assign D_out       = r_dout;
    assign D_oe        = !CS_n && !RD_n;
    assign VIDEO_R     = r_video_r;
    assign VIDEO_G     = r_video_g;
    assign VIDEO_B     = r_video_b;
    assign VIDEO_VALID = r_video_valid;
    assign CK          = r_ck;
    assign MODE        = r_cr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_vce_palette_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vce_palette_engine
// Purpose  : Self-checking bench for vce_palette_engine against a behavioural
//            model of the colour RAM, CPU registers, divider and pixel path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vce_palette_engine;

    localparam int ENTRIES  = 512;
    localparam int CBITS    = 3;
    localparam int OUT_BITS = 8;
    localparam int AW       = 9;
    localparam int EW       = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1;
    logic [2:0]    A = 3'd0;
    logic [7:0]    D_in = 8'h00;
    logic [7:0]    D_out;
    logic          D_oe;
    logic [AW-1:0] VD = '0;
    logic          HSYN = 1'b1, VSYN = 1'b1;
    logic [OUT_BITS-1:0] VIDEO_R, VIDEO_G, VIDEO_B;
    logic          VIDEO_VALID, CK;
    logic [1:0]    MODE;

    vce_palette_engine #(.ENTRIES(ENTRIES), .CBITS(CBITS), .OUT_BITS(OUT_BITS)) dut (
        .clock(clock), .reset(reset), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
        .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe), .VD(VD),
        .HSYN(HSYN), .VSYN(VSYN), .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G),
        .VIDEO_B(VIDEO_B), .VIDEO_VALID(VIDEO_VALID), .CK(CK), .MODE(MODE)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cram [ENTRIES];
    bit m_known[ENTRIES];
    int m_addr = 0, m_low = 0, m_cr = 0;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int due;
        bit known;
        int rgb;
    } px_t;
    px_t q[$];

    int last_ck = -1;
    int rel_cyc = 0;
    bit first_ck = 1'b0;
    bit ck_resync = 1'b0;
    int last_rgb = 0;
    bit last_known = 1'b0;

    int  vd_fix = -1;
    bit  hs_lo = 1'b0, vs_lo = 1'b0, sync_rand = 1'b0;

    function automatic int expand(input int c);
        int acc = 0;
        int nb = 0;
        while (nb < OUT_BITS) begin
            acc = (acc << CBITS) | c;
            nb += CBITS;
        end
        return acc >> (nb - OUT_BITS);
    endfunction

    function automatic int entry_rgb(input int e);
        int b = e & ((1 << CBITS) - 1);
        int r = (e >> CBITS) & ((1 << CBITS) - 1);
        int g = (e >> (2 * CBITS)) & ((1 << CBITS) - 1);
        return (expand(r) << 16) | (expand(g) << 8) | expand(b);
    endfunction

    function automatic int period(input int mode);
        return (mode == 0) ? 4 : (mode == 1) ? 3 : 2;
    endfunction

    // Pixel inputs change mid-cycle, away from the sampling edge.
    always @(posedge clock) begin
        #2;
        VD   = (vd_fix >= 0) ? AW'(vd_fix) : AW'($urandom % ENTRIES);
        HSYN = hs_lo ? 1'b0 : (sync_rand ? ($urandom % 8 != 0) : 1'b1);
        VSYN = vs_lo ? 1'b0 : (sync_rand ? ($urandom % 8 != 0) : 1'b1);
    end

    // Monitor: CK cadence, MODE, and the pixel pipeline against the model.
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            last_ck    = -1;
            last_rgb   = 0;
            last_known = 1'b1;
        end else begin
            if (ck_resync) begin
                last_ck   = -1;
                ck_resync = 1'b0;
            end
            check("mode", 32'(MODE), 32'(m_cr & 3));
            if (CK) begin
                px_t p;
                if (first_ck) begin
                    check("ck_first", 32'(cyc - rel_cyc), 32'd3);
                    first_ck = 1'b0;
                end else if (last_ck >= 0) begin
                    check("ck_period", 32'(cyc - last_ck), 32'(period(m_cr & 3)));
                end
                last_ck = cyc;
                p.due = cyc + 2;
                if (!HSYN || !VSYN) begin
                    p.known = 1'b1;
                    p.rgb   = 0;
                end else begin
                    p.known = m_known[VD];
                    p.rgb   = entry_rgb(m_cram[VD]);
                end
                q.push_back(p);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                check("video_valid", 32'(VIDEO_VALID), 32'd1);
                if (q[0].known) check("video_rgb", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'(q[0].rgb));
                last_rgb   = q[0].rgb;
                last_known = q[0].known;
                void'(q.pop_front());
            end else begin
                check("video_valid_idle", 32'(VIDEO_VALID), 32'd0);
                if (last_known) check("video_hold", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'(last_rgb));
            end
        end
    end

    // ---------------- CPU transactions ----------------
    task automatic cpu_write(input int a, input int d);
        @(posedge clock); #1;
        CS_n = 1'b0; WR_n = 1'b0; A = 3'(a); D_in = 8'(d);
        @(posedge clock);
        @(posedge clock); #1;
        CS_n = 1'b1; WR_n = 1'b1;
        case (a)
            0: begin m_cr = d; ck_resync = 1'b1; end
            2: m_addr = ((m_addr & 'hFF00) | d) % ENTRIES;
            3: m_addr = ((d << 8) | (m_addr & 'hFF)) % ENTRIES;
            4: m_low = d;
            5: begin
                m_cram[m_addr]  = ((d << 8) | m_low) & ((1 << EW) - 1);
                m_known[m_addr] = 1'b1;
                m_addr = (m_addr + 1) % ENTRIES;
            end
            default: ;
        endcase
        @(posedge clock); #1;
    endtask

    task automatic cpu_read(input int a, output int val);
        int exp;
        bit chk;
        @(posedge clock); #1;
        CS_n = 1'b0; RD_n = 1'b0; A = 3'(a);
        #1 check("d_oe_on", 32'(D_oe), 32'd1);
        @(posedge clock);
        @(posedge clock); #1;
        val = int'(D_out);
        chk = 1'b1;
        exp = 0;
        case (a)
            0: exp = m_cr;
            4: begin exp = m_cram[m_addr] & 'hFF; chk = m_known[m_addr]; end
            5: begin
                exp = m_cram[m_addr] >> 8;
                chk = m_known[m_addr];
                m_addr = (m_addr + 1) % ENTRIES;
            end
            2, 3: chk = 1'b0;
            default: exp = 0;
        endcase
        if (chk) check($sformatf("read_a%0d", a), 32'(val), 32'(exp));
        CS_n = 1'b1; RD_n = 1'b1;
        #1 check("d_oe_off", 32'(D_oe), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clock); #1;
        reset = 1'b1; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
        m_cr = 0; m_addr = 0; m_low = 0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        rel_cyc = cyc;
        first_ck = 1'b1;
    endtask

    task automatic measure_ck(output int gap);
        int c1 = -1;
        int c2 = -1;
        for (int i = 0; i < 40 && c2 < 0; i++) begin
            @(negedge clock);
            if (CK) begin
                if (c1 < 0) c1 = cyc;
                else c2 = cyc;
            end
        end
        gap = (c2 >= 0) ? c2 - c1 : -1;
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (VIDEO_VALID) found = 1'b1;
        end
    endtask

    initial begin
        int v, gap, first_lo, second_lo;
        bit found;

        do_reset(3);
        check("rst_dout", 32'(D_out), 32'h0);
        check("rst_video", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'h0);
        check("rst_valid", 32'(VIDEO_VALID), 32'd0);
        check("rst_ck", 32'(CK), 32'd0);

        // Basic write / read-back.
        cpu_write(2, 'h10); cpu_write(4, 'hC5); cpu_write(5, 'h01);
        cpu_write(2, 'h10);
        cpu_read(4, v); check("tp_lo", 32'(v), 32'hC5);
        cpu_read(5, v); check("tp_hi", 32'(v), 32'h01);
        cpu_read(0, v); check("tp_cr", 32'(v), 32'h00);

        // Fill all entries starting at the last address; pointer wraps.
        cpu_write(3, 'h01); cpu_write(2, 'hFF);
        first_lo = 0; second_lo = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            int lo = int'($urandom % 256);
            if (i == 0) first_lo = lo;
            if (i == 1) second_lo = lo;
            cpu_write(4, lo);
            cpu_write(5, int'($urandom % 256));
        end
        cpu_read(4, v); check("wrap_end_addr", 32'(v), 32'(first_lo));
        cpu_write(3, 0); cpu_write(2, 0);
        cpu_read(4, v); check("wrap_entry0", 32'(v), 32'(second_lo));

        // Colour expansion: entry 3 = 9'b101_010_111.
        cpu_write(3, 0); cpu_write(2, 3); cpu_write(4, 'h57); cpu_write(5, 'h01);
        vd_fix = 3;
        repeat (10) @(posedge clock);
        wait_valid(found);
        check("px_found", 32'(found), 32'd1);
        check("px_r", 32'(VIDEO_R), 32'h49);
        check("px_g", 32'(VIDEO_G), 32'hB6);
        check("px_b", 32'(VIDEO_B), 32'hFF);

        // Sync blanking.
        hs_lo = 1'b1;
        repeat (10) @(posedge clock);
        wait_valid(found);
        check("hblank", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'h0);
        hs_lo = 1'b0; vs_lo = 1'b1;
        repeat (10) @(posedge clock);
        wait_valid(found);
        check("vblank", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'h0);
        vs_lo = 1'b0; vd_fix = -1;

        // Divider modes.
        cpu_write(0, 1);
        measure_ck(gap); check("ck_gap_m1", 32'(gap), 32'd3);
        check("mode_m1", 32'(MODE), 32'd1);
        cpu_write(0, 2);
        measure_ck(gap); check("ck_gap_m2", 32'(gap), 32'd2);
        check("mode_m2", 32'(MODE), 32'd2);

        // Randomised CPU traffic with random pixels and syncs.
        sync_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int a = int'($urandom % 8);
            if ($urandom % 2 == 0) begin
                if (a == 3) cpu_write(a, int'($urandom % 4));
                else cpu_write(a, int'($urandom % 256));
            end else begin
                cpu_read(a, v);
            end
            repeat ($urandom % 3) @(posedge clock);
        end
        sync_rand = 1'b0;

        // Reset in the middle of a data-high write.
        cpu_write(3, 0); cpu_write(2, 'h20); cpu_write(4, 'h5A);
        @(posedge clock); #1;
        CS_n = 1'b0; WR_n = 1'b0; A = 3'd5; D_in = 8'h77;
        @(posedge clock); #1;
        reset = 1'b1;
        m_cr = 0; m_addr = 0; m_low = 0;
        @(posedge clock); #1;
        CS_n = 1'b1; WR_n = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        rel_cyc = cyc;
        first_ck = 1'b1;
        check("mid_rst_dout", 32'(D_out), 32'h0);
        check("mid_rst_video", {8'h00, VIDEO_R, VIDEO_G, VIDEO_B}, 32'h0);
        check("mid_rst_mode", 32'(MODE), 32'd0);
        cpu_read(4, v);
        cpu_write(3, 0); cpu_write(2, 'h20);
        cpu_read(4, v);
        cpu_read(5, v);
        repeat (20) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
